dmem_arbiter: RTL and testbench

//  Two-port arbiter in front of the single-port DataMemory.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter: two-port arbiter serialising accesses into single-port DataMemory.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break (else port 0 priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic [WIDTH-1:0] addr0_i,
  input  logic [WIDTH-1:0] addr1_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic [WIDTH-1:0] wdata1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             err0_o,
  output logic             err1_o,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             busy_o,
  output logic             owner_o
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_ACCESS = 2'd1;
  localparam logic [1:0]       S_RESP   = 2'd2;
  localparam logic [WIDTH-3:0] DEPTH_W  = (WIDTH-2)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             last_winner_q, last_winner_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             grant;
  logic             winner;
  logic [WIDTH-1:0] win_addr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req0_i | req1_i) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: memory strobes come from registered state only, never from req.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    mem_read_o  = (state_q == S_ACCESS) & ~we_q & ~err_q;
    mem_write_o = (state_q == S_ACCESS) &  we_q & ~err_q;
    ack0_o      = 1'b0;
    ack1_o      = 1'b0;
    err0_o      = 1'b0;
    err1_o      = 1'b0;
    rdata0_o    = '0;
    rdata1_o    = '0;
    if (state_q == S_RESP) begin
      if (owner_q) begin
        ack1_o   = 1'b1;
        err1_o   = err_q;
        rdata1_o = rdata_q;
      end else begin
        ack0_o   = 1'b1;
        err0_o   = err_q;
        rdata0_o = rdata_q;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign owner_o     = owner_q;

  always_comb begin
    grant = (state_q == S_IDLE) & (req0_i | req1_i);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (req0_i & req1_i) winner = ~last_winner_q;
    else                 winner = ~req0_i;
`else
    winner = ~req0_i;
`endif
    win_addr = winner ? addr1_i : addr0_i;
  end

  // Command latch at grant, read-data capture on the ACCESS edge.
  always_comb begin
    owner_d       = owner_q;
    we_d          = we_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    last_winner_d = last_winner_q;
    if (grant) begin
      owner_d       = winner;
      we_d          = winner ? we1_i : we0_i;
      addr_d        = win_addr;
      wdata_d       = winner ? wdata1_i : wdata0_i;
      err_d         = (win_addr[WIDTH-1:2] >= DEPTH_W);
      last_winner_d = winner;
    end
    if (state_q == S_ACCESS) begin
      rdata_d = (~we_q & ~err_q) ? mem_rdata_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      last_winner_q <= 1'b1;
    end else begin
      owner_q       <= owner_d;
      we_q          <= we_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      last_winner_q <= last_winner_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed accesses against a reference memory, scoreboarded acks.
`default_nettype none

module tb_dmem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic             clk, rst_n;
  logic             req0_i, req1_i, we0_i, we1_i;
  logic [WIDTH-1:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic             ack0_o, ack1_o, err0_o, err1_o;
  logic [WIDTH-1:0] rdata0_o, rdata1_o;
  logic             mem_read_o, mem_write_o;
  logic [WIDTH-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic             busy_o, owner_o;

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory stand-in: combinational read, synchronous write; not cleared by reset.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  wire              mem_in_range = (mem_addr_o[WIDTH-1:2] < DEPTH);
  assign mem_rdata_i = mem_in_range ? mem[mem_addr_o[6:2]] : '0;
  always @(posedge clk) if (mem_write_o && mem_in_range) mem[mem_addr_o[6:2]] <= mem_wdata_o;

  typedef struct packed {
    logic             port;
    logic             err;
    logic [WIDTH-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.port  = p;
    e.err   = (a[31:2] >= DEPTH);
    e.rdata = (!we && !e.err) ? ref_mem[a[6:2]] : '0;
    if (we && !e.err) ref_mem[a[6:2]] = d;
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic access(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   got = 0, saw_rd = 0, saw_wr = 0;
    int   got_cyc = 0;
    logic exp_err = (a[31:2] >= DEPTH);
    push_exp(p, we, a, d);
    if (p) begin req1_i = 1; we1_i = we; addr1_i = a; wdata1_i = d; end
    else   begin req0_i = 1; we0_i = we; addr0_i = a; wdata0_i = d; end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      saw_rd |= mem_read_o;
      saw_wr |= mem_write_o;
      if (ack0_o || ack1_o) begin got = 1; got_cyc = c; break; end
    end
    e = sb.pop_front();
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("ack_latency", 32'(got_cyc), 32'd2);
      chk("ack_owner", 32'(p ? ack1_o : ack0_o), 32'd1);
      chk("ack_nonowner", 32'(p ? ack0_o : ack1_o), 32'd0);
      chk("owner", 32'(owner_o), 32'(e.port));
      chk("err", 32'(p ? err1_o : err0_o), 32'(e.err));
      chk("rdata", p ? rdata1_o : rdata0_o, e.rdata);
    end
    chk("strobe_rd", 32'(saw_rd), 32'(!we && !exp_err));
    chk("strobe_wr", 32'(saw_wr), 32'(we && !exp_err));
    req0_i = 0; req1_i = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    rst_n = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strobes", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    chk("rst_acks", {30'd0, ack0_o, ack1_o}, 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Single write then read on port 1
    access(1, 1, 32'h08, 32'hDEAD_BEEF);
    access(1, 0, 32'h08, 32'h0);

    // Reset during ACCESS aborts the write
    req0_i = 1; we0_i = 1; addr0_i = 32'h10; wdata0_i = 32'h1234_5678;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy_o), 32'd1);
    chk("abort_wr_pre", 32'(mem_write_o), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_wr", 32'(mem_write_o), 32'd0);
    req0_i = 0; we0_i = 0;
    @(negedge clk);
    chk("abort_no_ack", {30'd0, ack0_o, ack1_o}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    access(0, 0, 32'h10, 32'h0);

    // Out-of-range read and write
    access(0, 0, 32'h80, 32'h0);
    access(1, 1, 32'hFC + 32'h4, 32'hCAFE_F00D);
    for (int i = 0; i < DEPTH; i++) access(0, 0, 32'(i * 4), 32'h0);

    // Tie: both requesters hold req for four accesses
    do_reset();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, i[0] ? 32'h0C : 32'h04, 32'h0);
`else
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h04, 32'h0);
`endif
    req0_i = 1; we0_i = 0; addr0_i = 32'h04;
    req1_i = 1; we1_i = 0; addr1_i = 32'h0C;
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack0_o || ack1_o) begin
        chk("tie_ack_cycle", 32'(c), 32'(2 + 3 * k));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tie_port", 32'(ack1_o), 32'(e.port));
          chk("tie_single_ack", 32'(ack0_o & ack1_o), 32'd0);
          chk("tie_rdata", ack1_o ? rdata1_o : rdata0_o, e.rdata);
        end
        k++;
      end
    end
    req0_i = 0; req1_i = 0;
    chk("tie_ack_count", 32'(k), 32'd4);
    sb.delete();
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
